fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding,
// parameter defaults and PC helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int          DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES   = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, inst} entries with flush; storage is registered
// so a pushed entry reaches the head on the following cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [63:0]              push_data_i,
  input  logic                     pop_i,
  output logic [63:0]              head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Flush wins over both push and pop; an empty queue ignores pops.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one-outstanding-request memory FSM feeding
// a small queue, with redirect flush and drain of an in-flight request.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  input  logic                   inst_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);
  localparam logic [CW:0] EXT_ONE   = (CW + 1)'(1);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  next_pc;
  logic [CW:0]  count_after;
  logic         push, pop;
  logic [63:0]  head;

  assign pop     = inst_valid && inst_ready;
  assign next_pc = fetch_pc_q + INST_BYTES;
  // Occupancy once this cycle's push and any concurrent pop have landed.
  assign count_after = {1'b0, count} + EXT_ONE - {{CW{1'b0}}, pop};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    if (redirect) fetch_pc_d = align_pc(redirect_pc);
    case (state_q)
      IDLE: begin
        if (!redirect && ({1'b0, count} < DEPTH_EXT)) begin
          state_d    = WAIT;
          req_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          // Without an ack the old request is still in flight and must be drained.
          state_d = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = next_pc;
          if (count_after < DEPTH_EXT) req_addr_d = next_pc;
          else                         state_d    = IDLE;
        end
      end
      DRAIN: begin
        // The ack retires the stale request; a redirect only retargets fetch_pc.
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign mem_req  = (state_q != IDLE);
  assign mem_addr = req_addr_q;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i ({fetch_pc_q, mem_rdata}),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (inst_valid),
    .count_o     (count)
  );

  assign inst_pc = head[63:32];
  assign inst    = head[31:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; the memory model returns the bitwise
// inverse of the request address as the instruction word.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", mem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    do_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_idle_req got=%b want=0", mem_req); end
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b want=1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got=%h want=00000000", mem_addr); end
  endtask

  // One-cycle-latency memory: every request is acked on its second cycle.
  task automatic test_stream();
    int n = 0;
    int first_req = -1;
    int first_vld = -1;
    logic seen = 1'b0;
    do_reset();
    inst_ready = 1'b1;
    for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
      step();
      if (mem_req && first_req < 0) first_req = cyc;
      if (inst_valid && first_vld < 0) first_vld = cyc;
      if (inst_valid) begin
        checks++; if (inst_pc !== 32'(n * 4)) begin errors++; $display("FAIL stream_pc%0d got=%h want=%h", n, inst_pc, 32'(n * 4)); end
        checks++; if (inst !== ~32'(n * 4)) begin errors++; $display("FAIL stream_inst%0d got=%h want=%h", n, inst, ~32'(n * 4)); end
        n++;
      end
      if (mem_req && seen) begin
        mem_ack = 1'b1; mem_rdata = ~mem_addr; seen = 1'b0;
      end else begin
        mem_ack = 1'b0; mem_rdata = '0; seen = mem_req;
      end
    end
    mem_ack = 1'b0; inst_ready = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL stream_timeout got=%0d want=4", n); end
    checks++; if (first_vld - first_req !== 2) begin errors++; $display("FAIL stream_latency got=%0d want=2", first_vld - first_req); end
  endtask

  task automatic test_full();
    int reqs = 0;
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (mem_req) reqs++;
      mem_ack = mem_req; mem_rdata = ~mem_addr;
      step();
    end
    mem_ack = 1'b0;
    checks++; if (reqs !== 4) begin errors++; $display("FAIL full_reqs got=%0d want=4", reqs); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d want=4", count); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_req got=%b want=0", mem_req); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL full_head got=%h want=00000000", inst_pc); end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL pop_count got=%0d want=3", count); end
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL refill_req got=%b want=1", mem_req); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL refill_addr got=%h want=00000010", mem_addr); end
    mem_ack = 1'b1; mem_rdata = ~mem_addr;
    step();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL refill_count got=%0d want=4", count); end
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL refill_single got=%b want=0", mem_req); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drain_req got=%b want=1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL drain_addr got=%h want=00000000", mem_addr); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d want=0", count); end
    step();
    step();
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL drain_hold got=%h want=00000000", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_idle got=%b want=0", mem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drain_discard got=%b want=0", inst_valid); end
    step();
    checks++; if (mem_addr !== 32'h100 || mem_req !== 1'b1) begin errors++; $display("FAIL drain_newaddr got=%h/%b want=00000100/1", mem_addr, mem_req); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count2 got=%0d want=0", count); end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    step();
    mem_ack = 1'b1; mem_rdata = ~mem_addr;
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL rap_setup got=%b/%h want=1/00000000", inst_valid, inst_pc); end
    mem_ack = 1'b1; mem_rdata = ~mem_addr; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    mem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rap_count got=%0d want=0", count); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rap_valid got=%b want=0", inst_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rap_idle got=%b want=0", mem_req); end
    step();
    checks++; if (mem_addr !== 32'h200 || inst_valid !== 1'b0) begin errors++; $display("FAIL rap_addr got=%h/%b want=00000200/0", mem_addr, inst_valid); end
    mem_ack = 1'b1; mem_rdata = ~mem_addr; inst_ready = 1'b1;
    step();
    mem_ack = 1'b0; inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin errors++; $display("FAIL rap_head got=%b/%h want=1/00000200", inst_valid, inst_pc); end
    checks++; if (inst !== ~32'h200) begin errors++; $display("FAIL rap_inst got=%h want=%h", inst, ~32'h200); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    mem_ack = 1'b1; mem_rdata = ~mem_addr;
    step();
    mem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL arst_setup got=%b/%b want=1/1", inst_valid, mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL arst_req got=%b want=0", mem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b want=0", inst_valid); end
    step();
    rst = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL arst_restart got=%b/%h want=1/00000000", mem_req, mem_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    int n = 0;
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wrap_idle got=%b want=0", mem_req); end
    step();
    checks++; if (mem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr got=%h want=fffffff8", mem_addr); end
    inst_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
      if (inst_valid) begin
        checks++; if (inst_pc !== exp_pc[n]) begin errors++; $display("FAIL wrap_pc%0d got=%h want=%h", n, inst_pc, exp_pc[n]); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count%0d got=%0d want=1", n, count); end
        n++;
      end
      mem_ack = mem_req; mem_rdata = ~mem_addr;
      step();
    end
    mem_ack = 1'b0; inst_ready = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL wrap_timeout got=%0d want=3", n); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_drain();
    test_redirect_ack_pop();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
